// File: rtl/jam_cost_arbiter_if.sv
// Request/response bus between the cost-ROM requesters (JAM cores, preload engine) and jam_cost_arbiter.
// The master side also supplies the combinational ROM data for the address the arbiter drives.
interface jam_cost_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int COST_W = 7
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_burst;
  logic [3*NREQ-1:0] req_w;
  logic [3*NREQ-1:0] req_j;
  logic [NREQ-1:0]   gnt;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [COST_W-1:0] Cost;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_last;
  logic [COST_W-1:0] rsp_cost;
  logic              busy;

  modport master (
    output req, req_burst, req_w, req_j, Cost,
    input  gnt, W, J, rsp_valid, rsp_last, rsp_cost, busy
  );

  modport slave (
    input  req, req_burst, req_w, req_j, Cost,
    output gnt, W, J, rsp_valid, rsp_last, rsp_cost, busy
  );
endinterface

// File: rtl/jam_cost_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational cost-ROM port among NREQ requesters,
// with single reads and fixed-W, J-incrementing burst reads returned through a registered response.
module jam_cost_arbiter #(
  parameter int NREQ      = 2,
  parameter int COST_W    = 7,
  parameter int BURST_LEN = 8
) (
  input logic               CLK,
  input logic               RST,
  jam_cost_arbiter_if.slave bus
);

  localparam int         IDX_W       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0] LAST_BEAT   = 3'(BURST_LEN - 1);
  localparam logic [2:0] PENULT_BEAT = 3'(BURST_LEN - 2);
  localparam bit         BURST_EN    = (BURST_LEN > 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  owner_q;
  logic [2:0]        w_q;
  logic [2:0]        j_q;
  logic [2:0]        beat_q;
  logic              pend_valid_q;
  logic              pend_burst_q;
  logic [IDX_W-1:0]  pend_owner_q;
  logic [2:0]        pend_w_q;
  logic [2:0]        pend_j_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic              rsp_last_q;
  logic [COST_W-1:0] rsp_cost_q;

  logic              any_req_d;
  logic [IDX_W-1:0]  win_d;
  logic [2:0]        win_w_d;
  logic [2:0]        win_j_d;
  logic              win_burst_d;
  logic [NREQ-1:0]   win_onehot_d;
  logic [NREQ-1:0]   owner_onehot_d;
  int                best_d;
  int                dist_d;

  // Winner is the requesting index closest after the pointer (distance 0 = pointer+1).
  always_comb begin
    any_req_d   = |bus.req;
    win_d       = ptr_q;
    win_w_d     = '0;
    win_j_d     = '0;
    win_burst_d = 1'b0;
    best_d      = NREQ;
    dist_d      = 0;
    for (int k = 0; k < NREQ; k++) begin
      dist_d = (k - int'(ptr_q) - 1 + 2 * NREQ) % NREQ;
      if (bus.req[k] && (dist_d < best_d)) begin
        best_d      = dist_d;
        win_d       = IDX_W'(k);
        win_w_d     = bus.req_w[3*k +: 3];
        win_j_d     = bus.req_j[3*k +: 3];
        win_burst_d = bus.req_burst[k];
      end
    end
    win_onehot_d   = NREQ'(1) << win_d;
    owner_onehot_d = NREQ'(1) << owner_q;
  end

  // A grant made while the final burst address is issued is parked in pend_* and
  // loaded onto the port at the next edge, so the port never idles between owners.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      ptr_q        <= IDX_W'(NREQ - 1);
      owner_q      <= '0;
      w_q          <= '0;
      j_q          <= '0;
      beat_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_burst_q <= 1'b0;
      pend_owner_q <= '0;
      pend_w_q     <= '0;
      pend_j_q     <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_last_q   <= 1'b0;
      rsp_cost_q   <= '0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      unique case (state_q)
        IDLE, ISSUE: begin
          if (state_q == ISSUE) begin
            rsp_valid_q <= owner_onehot_d;
            rsp_last_q  <= 1'b1;
            rsp_cost_q  <= bus.Cost;
          end
          if (any_req_d) begin
            ptr_q   <= win_d;
            owner_q <= win_d;
            gnt_q   <= win_onehot_d;
            w_q     <= win_w_d;
            j_q     <= win_j_d;
            beat_q  <= '0;
            state_q <= (win_burst_d && BURST_EN) ? BURST : ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        BURST: begin
          rsp_valid_q <= owner_onehot_d;
          rsp_cost_q  <= bus.Cost;
          rsp_last_q  <= (beat_q == LAST_BEAT);
          if (beat_q != LAST_BEAT) begin
            j_q    <= j_q + 3'd1;
            beat_q <= beat_q + 3'd1;
            if ((beat_q == PENULT_BEAT) && any_req_d) begin
              ptr_q        <= win_d;
              gnt_q        <= win_onehot_d;
              pend_valid_q <= 1'b1;
              pend_owner_q <= win_d;
              pend_w_q     <= win_w_d;
              pend_j_q     <= win_j_d;
              pend_burst_q <= win_burst_d && BURST_EN;
            end
          end else if (pend_valid_q) begin
            pend_valid_q <= 1'b0;
            owner_q      <= pend_owner_q;
            w_q          <= pend_w_q;
            j_q          <= pend_j_q;
            beat_q       <= '0;
            state_q      <= pend_burst_q ? BURST : ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.W         = w_q;
  assign bus.J         = j_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_cost  = rsp_cost_q;
  assign bus.busy      = (state_q != IDLE) || (|rsp_valid_q);

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Bench for jam_cost_arbiter: directed scenarios plus random requester traffic, checked by a
// port-schedule reference model feeding a response queue that a negedge monitor drains.
module tb_jam_cost_arbiter;
  localparam int NREQ      = 2;
  localparam int COST_W    = 7;
  localparam int BURST_LEN = 8;

  typedef struct {
    int owner;
    int cost;
    int last;
    int w;
    int j;
    int cycle;
  } rsp_t;

  logic CLK;
  logic RST;
  logic [COST_W-1:0] rom [64];

  jam_cost_arbiter_if #(.NREQ(NREQ), .COST_W(COST_W)) bus ();

  jam_cost_arbiter #(.NREQ(NREQ), .COST_W(COST_W), .BURST_LEN(BURST_LEN)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  assign bus.Cost = rom[{bus.W, bus.J}];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   tests     = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   ptrM      = NREQ - 1;
  int   lastAddr  = -1;
  int   burstTail = -1;
  int   expGnt    = 0;
  int   win, w0, j0, len, start;
  int   lastW     = 0;
  int   lastJ     = 0;
  int   lastCost  = 0;
  int   expW, expJ;
  bit   addrFound;
  rsp_t e;
  rsp_t rspQ [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Reference model: the port issues one address per edge in grant order. A grant may only be
  // made once the port has no future addresses booked (or on the edge booking a burst's last
  // one), never on the edge right after a burst ends; each address returns one edge later.
  always @(posedge CLK) begin
    cyc++;
    expGnt = 0;
    if (!RST) begin
      ptrM      = NREQ - 1;
      lastAddr  = -1;
      burstTail = -1;
      rspQ.delete();
    end else if (cyc >= lastAddr && cyc != burstTail && bus.req != '0) begin
      win = -1;
      for (int d = 1; d <= NREQ; d++)
        if (win < 0 && ((int'(bus.req) >> ((ptrM + d) % NREQ)) & 1) == 1)
          win = (ptrM + d) % NREQ;
      ptrM   = win;
      expGnt = 1 << win;
      w0     = (int'(bus.req_w) >> (3 * win)) & 7;
      j0     = (int'(bus.req_j) >> (3 * win)) & 7;
      len    = (((int'(bus.req_burst) >> win) & 1) == 1) ? BURST_LEN : 1;
      start  = (cyc > lastAddr) ? cyc : lastAddr + 1;
      for (int b = 0; b < len; b++)
        rspQ.push_back('{win, int'(rom[w0 * 8 + (j0 + b) % 8]), (b == len - 1) ? 1 : 0,
                         w0, (j0 + b) % 8, start + b + 1});
      lastAddr = start + len - 1;
      if (len > 1) burstTail = lastAddr + 1;
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      rspQ.delete();
      lastW    = 0;
      lastJ    = 0;
      lastCost = 0;
      checkOutput("reset_outputs_zero",
                  {31'd0, (|bus.gnt) || (|bus.rsp_valid) || bus.rsp_last || (|bus.rsp_cost) ||
                          (|bus.W) || (|bus.J) || bus.busy}, 0);
    end else begin
      checkOutput("gnt", {{(32-NREQ){1'b0}}, bus.gnt}, expGnt);
      checkOutput("busy", {31'd0, bus.busy}, (rspQ.size() != 0) ? 1 : 0);
      addrFound = 1'b0;
      expW = 0;
      expJ = 0;
      foreach (rspQ[i])
        if (rspQ[i].cycle == cyc + 1) begin
          expW      = rspQ[i].w;
          expJ      = rspQ[i].j;
          addrFound = 1'b1;
        end
      if (addrFound) begin
        lastW = expW;
        lastJ = expJ;
      end
      checkOutput("addr_W", {29'd0, bus.W}, lastW);
      checkOutput("addr_J", {29'd0, bus.J}, lastJ);
      if (rspQ.size() != 0 && rspQ[0].cycle == cyc) begin
        e = rspQ.pop_front();
        checkOutput("rsp_valid", {{(32-NREQ){1'b0}}, bus.rsp_valid}, 1 << e.owner);
        checkOutput("rsp_cost", {{(32-COST_W){1'b0}}, bus.rsp_cost}, e.cost);
        checkOutput("rsp_last", {31'd0, bus.rsp_last}, e.last);
        lastCost = e.cost;
      end else begin
        checkOutput("rsp_valid_idle", {{(32-NREQ){1'b0}}, bus.rsp_valid}, 0);
        checkOutput("rsp_cost_hold", {{(32-COST_W){1'b0}}, bus.rsp_cost}, lastCost);
      end
    end
  end

  task automatic applyStimulus(input int k, input bit burst, input int w, input int j);
    bus.req       = bus.req | NREQ'(1 << k);
    bus.req_burst = burst ? (bus.req_burst | NREQ'(1 << k)) : (bus.req_burst & ~NREQ'(1 << k));
    bus.req_w     = (bus.req_w & ~(3*NREQ)'(7 << (3 * k))) | (3*NREQ)'((w & 7) << (3 * k));
    bus.req_j     = (bus.req_j & ~(3*NREQ)'(7 << (3 * k))) | (3*NREQ)'((j & 7) << (3 * k));
  endtask

  // Requesters withdraw once granted unless told to keep holding.
  task automatic step(input bit dropOnGnt);
    @(posedge CLK);
    #1;
    if (dropOnGnt) bus.req = bus.req & ~bus.gnt;
  endtask

  task automatic randomStep();
    bit on, g;
    @(posedge CLK);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      on = ((int'(bus.req) >> k) & 1) == 1;
      g  = ((int'(bus.gnt) >> k) & 1) == 1;
      if (on && g) begin
        if ($urandom_range(1, 0) == 0)
          bus.req = bus.req & ~NREQ'(1 << k);
        else
          applyStimulus(k, $urandom_range(2, 0) == 0, int'($urandom_range(7, 0)), int'($urandom_range(7, 0)));
      end else if (!on && $urandom_range(3, 0) == 0) begin
        applyStimulus(k, $urandom_range(2, 0) == 0, int'($urandom_range(7, 0)), int'($urandom_range(7, 0)));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) rom[a] = COST_W'(a);
    RST           = 1'b0;
    bus.req       = '0;
    bus.req_burst = '0;
    bus.req_w     = '0;
    bus.req_j     = '0;

    // Reset held with random requests, then released idle.
    repeat (4) begin
      step(1'b0);
      bus.req       = NREQ'($urandom);
      bus.req_burst = NREQ'($urandom);
      bus.req_w     = (3*NREQ)'($urandom);
      bus.req_j     = (3*NREQ)'($urandom);
    end
    step(1'b0);
    bus.req = '0;
    step(1'b0);
    RST = 1'b1;
    repeat (3) step(1'b1);

    // Single read: Cost = 8W+J, expect 21.
    applyStimulus(0, 1'b0, 2, 5);
    repeat (4) step(1'b1);

    // Back-to-back contention with both requests held.
    applyStimulus(0, 1'b0, 1, 2);
    applyStimulus(1, 1'b0, 4, 3);
    repeat (6) step(1'b0);
    bus.req = '0;
    repeat (3) step(1'b1);

    // Wrapping burst on requester 1.
    applyStimulus(1, 1'b1, 3, 6);
    repeat (12) step(1'b1);

    // Burst with a competing single read raised part-way through.
    applyStimulus(1, 1'b1, 3, 6);
    repeat (4) step(1'b1);
    applyStimulus(0, 1'b0, 6, 1);
    repeat (12) step(1'b1);

    // Reset asserted mid-burst, then both requesters compete from the reset pointer.
    applyStimulus(1, 1'b1, 5, 2);
    repeat (5) step(1'b1);
    RST = 1'b0;
    repeat (2) step(1'b0);
    applyStimulus(0, 1'b0, 7, 7);
    applyStimulus(1, 1'b0, 0, 4);
    RST = 1'b1;
    repeat (6) step(1'b1);

    // Random traffic against a random ROM image.
    bus.req = '0;
    repeat (4) step(1'b1);
    for (int a = 0; a < 64; a++) rom[a] = COST_W'($urandom);
    step(1'b1);
    repeat (400) randomStep();
    bus.req = '0;
    repeat (24) step(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
